pc_unit: RTL

//  Registered program-counter unit for the lab CPU. It holds the PC and selects the next value

---
 rtl/pc_unit_pkg.sv | 20 ++
 rtl/pc_unit_if.sv | 31 +++
 rtl/pc_unit_ret_stack.sv | 57 +++++
 rtl/pc_unit.sv | 97 +++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared defaults and the next-PC source encoding for the program-counter unit.
package pc_unit_pkg;

  localparam int unsigned PcWDef       = 16;
  localparam int unsigned JaddrWDef    = 12;
  localparam int unsigned OffWDef      = 8;
  localparam int unsigned StackDepthDef = 8;
  localparam int unsigned ResetPcDef   = 0;

  // Source of next_pc; also useful as a trace tag.
  typedef enum logic [2:0] {
    SelStall,
    SelInc,
    SelJump,
    SelBranch,
    SelCall,
    SelRet
  } pc_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// Decoder-side control/immediate bundle and PC/stack status returned to the fetch stage.
interface pc_unit_if
  import pc_unit_pkg::*;
#(
  parameter int unsigned PC_W    = PcWDef,
  parameter int unsigned JADDR_W = JaddrWDef,
  parameter int unsigned OFF_W   = OffWDef
);
  logic               stall;
  logic               jump_en;
  logic [JADDR_W-1:0] jump_addr;
  logic               branch_en;
  logic [OFF_W-1:0]   branch_off;
  logic               call_en;
  logic               ret_en;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    next_pc;
  logic               stack_empty;
  logic               stack_full;
  logic               stack_err;

  modport master (
    output stall, jump_en, jump_addr, branch_en, branch_off, call_en, ret_en,
    input  pc, next_pc, stack_empty, stack_full, stack_err
  );

  modport slave (
    input  stall, jump_en, jump_addr, branch_en, branch_off, call_en, ret_en,
    output pc, next_pc, stack_empty, stack_full, stack_err
  );
endinterface

// File: rtl/pc_unit_ret_stack.sv
// LIFO return-address stack. Pushes when full and pops when empty are ignored;
// reset only clears the pointer, which is enough to discard the contents.
module pc_unit_ret_stack
  import pc_unit_pkg::*;
#(
  parameter int unsigned W     = PcWDef,
  parameter int unsigned DEPTH = StackDepthDef
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] wr_idx, top_idx;
  logic          do_push, do_pop;

  assign wr_idx  = cnt_q[AW-1:0];
  // Modulo arithmetic on the low bits gives the top entry without a wider subtract.
  assign top_idx = wr_idx - AW'(1);
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[top_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (do_pop) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end else if (do_push) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter register with prioritised next-PC select (ret > call > jump > branch > inc)
// and a sticky overflow/underflow flag for the return-address stack.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned PC_W        = PcWDef,
  parameter int unsigned JADDR_W     = JaddrWDef,
  parameter int unsigned OFF_W       = OffWDef,
  parameter int unsigned STACK_DEPTH = StackDepthDef,
  parameter int unsigned RESET_PC    = ResetPcDef
) (
  input  logic      clk,
  input  logic      rst,
  pc_unit_if.slave  bus
);
  pc_sel_e         sel;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, jaddr_ext, off_ext, stack_top;
  logic            err_q, err_d;
  logic            push, pop, empty, full;

  assign pc_inc    = pc_q + PC_W'(1);
  assign jaddr_ext = PC_W'(bus.jump_addr);
  assign off_ext   = PC_W'($signed(bus.branch_off));

  always_comb begin
    sel = SelInc;
    if (bus.stall) begin
      sel = SelStall;
    end else if (bus.ret_en) begin
      sel = SelRet;
    end else if (bus.call_en) begin
      sel = SelCall;
    end else if (bus.jump_en) begin
      sel = SelJump;
    end else if (bus.branch_en) begin
      sel = SelBranch;
    end
  end

  always_comb begin
    pc_d  = pc_inc;
    push  = 1'b0;
    pop   = 1'b0;
    err_d = err_q;
    unique case (sel)
      SelStall:  pc_d = pc_q;
      SelRet: begin
        pop   = 1'b1;
        pc_d  = empty ? pc_inc : stack_top;
        err_d = err_q | empty;
      end
      SelCall: begin
        push  = 1'b1;
        pc_d  = jaddr_ext;
        err_d = err_q | full;
      end
      SelJump:   pc_d = jaddr_ext;
      SelBranch: pc_d = pc_q + off_ext;
      SelInc:    pc_d = pc_inc;
      default:   pc_d = pc_inc;
    endcase
    if (rst) begin
      pc_d = PC_W'(RESET_PC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= PC_W'(RESET_PC);
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  pc_unit_ret_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stack_top),
    .empty (empty),
    .full  (full)
  );

  assign bus.pc          = pc_q;
  assign bus.next_pc     = pc_d;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
  assign bus.stack_err   = err_q;

endmodule
